mem_arbiter: RTL and testbench

Two-master arbiter that shares the single memory2 port (address, to-memory data, write, from-memory data) between the cpu and a second bus master, such as a DMA or program loader. It sits between the masters and memory2 in `computer`. It grants one master per cycle using round-robin, with a bounded hold count and an optional lock. It issues one transfer per granted cycle and returns read data one cycle later.

---
 rtl/mem_arbiter_pkg.sv | 27 ++
 rtl/mem_arbiter_if.sv | 59 +++++
 rtl/mem_arbiter_mux.sv | 44 ++++
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master memory arbiter: default bus widths,
// owner encodings and a small helper for the round-robin handover.
package mem_arbiter_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  // Owner encoding is one-hot over the two masters so each grant is a
  // single flop bit; OWN_NONE means nobody holds the port.
  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_M0   = 2'b01,
    OWN_M1   = 2'b10
  } owner_t;

  // The master that is not o; OWN_NONE maps to OWN_NONE.
  function automatic owner_t other_owner(input owner_t o);
    owner_t r;
    case (o)
      OWN_M0:  r = OWN_M1;
      OWN_M1:  r = OWN_M0;
      default: r = OWN_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and memory2.
//
// Handshake: a master raises mX_req with addr/wdata/write/lock valid for the
// cycle. A transfer happens in every cycle where mX_gnt and mX_req are both
// high; there is no separate ready. Read data comes back on mX_rdata in the
// cycle after the transfer, qualified by mX_rvalid (rdata is 0 otherwise).
// The memory side presents one address per cycle and returns mem_from_memory
// one cycle later.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) ();

  logic          m0_req;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_write;
  logic          m0_lock;
  logic          m0_gnt;
  logic [DW-1:0] m0_rdata;
  logic          m0_rvalid;

  logic          m1_req;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_write;
  logic          m1_lock;
  logic          m1_gnt;
  logic [DW-1:0] m1_rdata;
  logic          m1_rvalid;

  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_to_memory;
  logic          mem_write;
  logic [DW-1:0] mem_from_memory;

  // Arbiter side: consumes requests, drives grants, read returns and memory.
  modport slave (
    input  m0_req, m0_addr, m0_wdata, m0_write, m0_lock,
    output m0_gnt, m0_rdata, m0_rvalid,
    input  m1_req, m1_addr, m1_wdata, m1_write, m1_lock,
    output m1_gnt, m1_rdata, m1_rvalid,
    output mem_address, mem_to_memory, mem_write,
    input  mem_from_memory
  );

  // Environment side: the masters plus memory2.
  modport master (
    output m0_req, m0_addr, m0_wdata, m0_write, m0_lock,
    input  m0_gnt, m0_rdata, m0_rvalid,
    output m1_req, m1_addr, m1_wdata, m1_write, m1_lock,
    input  m1_gnt, m1_rdata, m1_rvalid,
    input  mem_address, mem_to_memory, mem_write,
    output mem_from_memory
  );

endinterface

// File: rtl/mem_arbiter_mux.sv
// Combinational port mux: forwards the owning master's address, write data
// and write strobe to memory2, but only in a cycle that is a real transfer
// (grant and request both high). Idle cycles drive all zeros.
module mem_port_mux #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          m0_gnt,
  input  logic          m0_req,
  input  logic          m0_write,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m1_gnt,
  input  logic          m1_req,
  input  logic          m1_write,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [AW-1:0] address,
  output logic [DW-1:0] to_memory,
  output logic          write,
  output logic          m0_xfer,
  output logic          m1_xfer
);

  assign m0_xfer = m0_gnt & m0_req;
  assign m1_xfer = m1_gnt & m1_req;

  // Select the transferring master; grants are exclusive so order is moot.
  always_comb begin
    address   = '0;
    to_memory = '0;
    write     = 1'b0;
    if (m0_xfer) begin
      address   = m0_addr;
      to_memory = m0_wdata;
      write     = m0_write;
    end else if (m1_xfer) begin
      address   = m1_addr;
      to_memory = m1_wdata;
      write     = m1_write;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of memory2. One master owns the
// port at a time; ownership is bounded by MAX_HOLD consecutive transfers
// while the other master waits, unless the owner holds its lock. Reads
// return one cycle after their transfer, tagged to the issuing master even
// if the grant has moved on.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus,
  output owner_t        owner_state
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  owner_t        owner;
  owner_t        last;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_inc;
  logic          m0_xfer;
  logic          m1_xfer;
  logic          own_req;
  logic          oth_req;
  logic          own_lock;
  logic          under_limit;
  logic          keep;
  logic          m0_rvalid_q;
  logic          m1_rvalid_q;

  mem_port_mux #(
    .AW (AW),
    .DW (DW)
  ) u_mux (
    .m0_gnt    (bus.m0_gnt),
    .m0_req    (bus.m0_req),
    .m0_write  (bus.m0_write),
    .m0_addr   (bus.m0_addr),
    .m0_wdata  (bus.m0_wdata),
    .m1_gnt    (bus.m1_gnt),
    .m1_req    (bus.m1_req),
    .m1_write  (bus.m1_write),
    .m1_addr   (bus.m1_addr),
    .m1_wdata  (bus.m1_wdata),
    .address   (bus.mem_address),
    .to_memory (bus.mem_to_memory),
    .write     (bus.mem_write),
    .m0_xfer   (m0_xfer),
    .m1_xfer   (m1_xfer)
  );

  // Grants are straight decodes of the owner register (one-hot encoding).
  assign bus.m0_gnt  = (owner == OWN_M0);
  assign bus.m1_gnt  = (owner == OWN_M1);
  assign owner_state = owner;

  // Hold count as it will stand after this cycle's transfer, saturating.
  always_comb begin
    hold_inc = hold_cnt;
    if ((m0_xfer | m1_xfer) && (hold_cnt < HW'(MAX_HOLD))) begin
      hold_inc = hold_cnt + HW'(1);
    end
  end

  // View the request/lock inputs from the current owner's perspective; a
  // non-owner's lock never reaches the decision.
  always_comb begin
    own_req  = 1'b0;
    oth_req  = 1'b0;
    own_lock = 1'b0;
    case (owner)
      OWN_M0: begin
        own_req  = bus.m0_req;
        oth_req  = bus.m1_req;
        own_lock = bus.m0_lock;
      end
      OWN_M1: begin
        own_req  = bus.m1_req;
        oth_req  = bus.m0_req;
        own_lock = bus.m1_lock;
      end
      default: ;
    endcase
  end

  assign under_limit = (hold_inc < HW'(MAX_HOLD));
  assign keep        = own_req & (own_lock | under_limit | ~oth_req);

  // Owner FSM with hold counter and last-owner memory for tie-breaking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner    <= OWN_NONE;
      last     <= OWN_M1;
      hold_cnt <= '0;
    end else begin
      case (owner)
        OWN_NONE: begin
          hold_cnt <= '0;
          if (bus.m0_req && (!bus.m1_req || last == OWN_M1)) begin
            owner <= OWN_M0;
            last  <= OWN_M0;
          end else if (bus.m1_req) begin
            owner <= OWN_M1;
            last  <= OWN_M1;
          end
        end
        OWN_M0, OWN_M1: begin
          if (keep) begin
            hold_cnt <= hold_inc;
          end else if (oth_req) begin
            owner    <= other_owner(owner);
            last     <= other_owner(owner);
            hold_cnt <= '0;
          end else begin
            owner    <= OWN_NONE;
            hold_cnt <= '0;
          end
        end
        default: begin
          owner    <= OWN_NONE;
          hold_cnt <= '0;
        end
      endcase
    end
  end

  // Read tag: remember which master issued a read so its data returns to
  // it next cycle regardless of where the grant has gone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
    end else begin
      m0_rvalid_q <= m0_xfer & ~bus.m0_write;
      m1_rvalid_q <= m1_xfer & ~bus.m1_write;
    end
  end

  assign bus.m0_rvalid = m0_rvalid_q;
  assign bus.m1_rvalid = m1_rvalid_q;
  assign bus.m0_rdata  = m0_rvalid_q ? bus.mem_from_memory : '0;
  assign bus.m1_rdata  = m1_rvalid_q ? bus.mem_from_memory : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset state, single-master read, write
// then read, reset during a read, round-robin hold expiry and lock.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW       = 8;
  localparam int DW       = 8;
  localparam int MAX_HOLD = 4;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   reset;
  owner_t owner_state;

  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(
    .AW       (AW),
    .DW       (DW),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .owner_state (owner_state)
  );

  // ---------------- memory2 model ----------------
  logic [DW-1:0] wr_mem [256];
  bit   [255:0]  wr_vld;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    case (a)
      8'h10:   return 8'hA5;
      8'h41:   return 8'h11;
      8'h82:   return 8'h22;
      default: return a ^ 8'h5A;
    endcase
  endfunction

  always @(posedge clk) begin
    if (bus.mem_write) begin
      wr_mem[bus.mem_address] <= bus.mem_to_memory;
      wr_vld[bus.mem_address] <= 1'b1;
    end
    bus.mem_from_memory <= wr_vld[bus.mem_address] ? wr_mem[bus.mem_address]
                                                   : init_val(bus.mem_address);
  end

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [8:0]  exp_q[$];   // {issuing master, expected read data}

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Grants must never overlap.
  always @(negedge clk) begin
    if (reset === 1'b0) check_eq("gnt_exclusive", 32'(bus.m0_gnt & bus.m1_gnt), 32'h0);
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_all();
    bus.m0_req = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_write = 1'b0; bus.m0_lock = 1'b0;
    bus.m1_req = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_write = 1'b0; bus.m1_lock = 1'b0;
  endtask

  task automatic drive_m0(input logic req, input logic [AW-1:0] addr, input logic wr,
                          input logic [DW-1:0] wd, input logic lock);
    bus.m0_req = req; bus.m0_addr = addr; bus.m0_write = wr; bus.m0_wdata = wd; bus.m0_lock = lock;
  endtask

  task automatic drive_m1(input logic req, input logic [AW-1:0] addr, input logic wr,
                          input logic [DW-1:0] wd, input logic lock);
    bus.m1_req = req; bus.m1_addr = addr; bus.m1_write = wr; bus.m1_wdata = wd; bus.m1_lock = lock;
  endtask

  task automatic check_ret();
    logic [8:0] e;
    if (exp_q.size() == 0) begin
      check_eq("rr_queue_empty", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq("rr_m0_rvalid", 32'(bus.m0_rvalid), 32'(!e[8]));
      check_eq("rr_m1_rvalid", 32'(bus.m1_rvalid), 32'(e[8]));
      check_eq("rr_m0_rdata",  32'(bus.m0_rdata),  e[8] ? 32'h0 : 32'(e[7:0]));
      check_eq("rr_m1_rdata",  32'(bus.m1_rdata),  e[8] ? 32'(e[7:0]) : 32'h0);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit exp_m0;
    reset = 1'b1;
    idle_all();
    repeat (2) next_cycle();
    settle();
    check_eq("rst_m0_gnt",    32'(bus.m0_gnt), 32'h0);
    check_eq("rst_m1_gnt",    32'(bus.m1_gnt), 32'h0);
    check_eq("rst_m0_rvalid", 32'(bus.m0_rvalid), 32'h0);
    check_eq("rst_m1_rvalid", 32'(bus.m1_rvalid), 32'h0);
    check_eq("rst_m0_rdata",  32'(bus.m0_rdata), 32'h0);
    check_eq("rst_mem_write", 32'(bus.mem_write), 32'h0);
    check_eq("rst_mem_addr",  32'(bus.mem_address), 32'h0);
    check_eq("rst_mem_wdata", 32'(bus.mem_to_memory), 32'h0);
    check_eq("rst_owner",     32'(owner_state), 32'(OWN_NONE));

    // m0 alone reads 0x10 (memory holds 0xA5).
    next_cycle();
    reset = 1'b0;
    drive_m0(1'b1, 8'h10, 1'b0, 8'h00, 1'b0);
    settle();
    check_eq("rd_c0_m0_gnt", 32'(bus.m0_gnt), 32'h0);
    next_cycle(); settle();
    check_eq("rd_c1_m0_gnt",    32'(bus.m0_gnt), 32'h1);
    check_eq("rd_c1_m1_gnt",    32'(bus.m1_gnt), 32'h0);
    check_eq("rd_c1_mem_addr",  32'(bus.mem_address), 32'h10);
    check_eq("rd_c1_mem_write", 32'(bus.mem_write), 32'h0);
    next_cycle();
    bus.m0_req = 1'b0;
    settle();
    check_eq("rd_c2_m0_rvalid", 32'(bus.m0_rvalid), 32'h1);
    check_eq("rd_c2_m0_rdata",  32'(bus.m0_rdata), 32'hA5);
    check_eq("rd_c2_m1_rvalid", 32'(bus.m1_rvalid), 32'h0);
    check_eq("rd_c2_m1_rdata",  32'(bus.m1_rdata), 32'h0);
    check_eq("rd_c2_m0_gnt",    32'(bus.m0_gnt), 32'h1);
    check_eq("rd_c2_noxfer",    32'(bus.mem_address), 32'h0);
    next_cycle(); settle();
    check_eq("rd_c3_m0_gnt",    32'(bus.m0_gnt), 32'h0);
    check_eq("rd_c3_m0_rvalid", 32'(bus.m0_rvalid), 32'h0);
    check_eq("rd_c3_owner",     32'(owner_state), 32'(OWN_NONE));

    // m1 writes 0x3C to 0x20, then m0 reads it back with a direct handover.
    next_cycle();
    drive_m1(1'b1, 8'h20, 1'b1, 8'h3C, 1'b0);
    settle();
    check_eq("wr_a0_mem_write", 32'(bus.mem_write), 32'h0);
    next_cycle(); settle();
    check_eq("wr_a1_m1_gnt",    32'(bus.m1_gnt), 32'h1);
    check_eq("wr_a1_mem_write", 32'(bus.mem_write), 32'h1);
    check_eq("wr_a1_mem_addr",  32'(bus.mem_address), 32'h20);
    check_eq("wr_a1_mem_wdata", 32'(bus.mem_to_memory), 32'h3C);
    next_cycle();
    drive_m1(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    drive_m0(1'b1, 8'h20, 1'b0, 8'h00, 1'b0);
    settle();
    check_eq("wr_a2_mem_write", 32'(bus.mem_write), 32'h0);
    check_eq("wr_a2_m1_gnt",    32'(bus.m1_gnt), 32'h1);
    check_eq("wr_a2_m0_gnt",    32'(bus.m0_gnt), 32'h0);
    next_cycle(); settle();
    check_eq("wr_a3_m0_gnt",    32'(bus.m0_gnt), 32'h1);
    check_eq("wr_a3_m1_gnt",    32'(bus.m1_gnt), 32'h0);
    check_eq("wr_a3_mem_addr",  32'(bus.mem_address), 32'h20);
    check_eq("wr_a3_mem_write", 32'(bus.mem_write), 32'h0);
    next_cycle();
    bus.m0_req = 1'b0;
    settle();
    check_eq("wr_a4_m0_rvalid", 32'(bus.m0_rvalid), 32'h1);
    check_eq("wr_a4_m0_rdata",  32'(bus.m0_rdata), 32'h3C);
    check_eq("wr_a4_m1_rvalid", 32'(bus.m1_rvalid), 32'h0);
    next_cycle(); settle();
    check_eq("wr_a5_owner", 32'(owner_state), 32'(OWN_NONE));

    // Reset asserted during a read transfer.
    next_cycle();
    drive_m0(1'b1, 8'h10, 1'b0, 8'h00, 1'b0);
    settle();
    next_cycle(); settle();
    check_eq("rmr_b1_m0_gnt",   32'(bus.m0_gnt), 32'h1);
    check_eq("rmr_b1_mem_addr", 32'(bus.mem_address), 32'h10);
    reset = 1'b1;
    next_cycle(); settle();
    check_eq("rmr_b2_m0_rvalid", 32'(bus.m0_rvalid), 32'h0);
    check_eq("rmr_b2_m0_rdata",  32'(bus.m0_rdata), 32'h0);
    check_eq("rmr_b2_m0_gnt",    32'(bus.m0_gnt), 32'h0);
    check_eq("rmr_b2_mem_write", 32'(bus.mem_write), 32'h0);
    check_eq("rmr_b2_mem_addr",  32'(bus.mem_address), 32'h0);
    reset = 1'b0;
    next_cycle(); settle();
    check_eq("rmr_b3_m0_gnt",    32'(bus.m0_gnt), 32'h1);
    check_eq("rmr_b3_mem_write", 32'(bus.mem_write), 32'h0);
    next_cycle();
    bus.m0_req = 1'b0;
    settle();
    next_cycle(); settle();

    // Both masters read continuously from reset: m0 1-4, m1 5-8, m0 9-12.
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    drive_m0(1'b1, 8'h41, 1'b0, 8'h00, 1'b0);
    drive_m1(1'b1, 8'h82, 1'b0, 8'h00, 1'b0);
    settle();
    check_eq("rr_c0_owner", 32'(owner_state), 32'(OWN_NONE));
    for (int c = 1; c <= 12; c++) begin
      next_cycle(); settle();
      exp_m0 = (((c - 1) / 4) % 2) == 0;
      check_eq($sformatf("rr_c%0d_m0_gnt", c), 32'(bus.m0_gnt), 32'(exp_m0));
      check_eq($sformatf("rr_c%0d_m1_gnt", c), 32'(bus.m1_gnt), 32'(!exp_m0));
      if (c >= 2) check_ret();
      exp_q.push_back(exp_m0 ? {1'b0, 8'h11} : {1'b1, 8'h22});
    end
    next_cycle();
    idle_all();
    settle();
    check_ret();
    next_cycle(); settle();
    check_eq("rr_idle_owner", 32'(owner_state), 32'(OWN_NONE));

    // m0 locks through 10 transfers while m1 (also locking) waits.
    next_cycle();
    drive_m0(1'b1, 8'h41, 1'b0, 8'h00, 1'b1);
    drive_m1(1'b1, 8'h82, 1'b0, 8'h00, 1'b1);
    settle();
    for (int i = 1; i <= 10; i++) begin
      next_cycle(); settle();
      check_eq($sformatf("lk_t%0d_m0_gnt", i), 32'(bus.m0_gnt), 32'h1);
      check_eq($sformatf("lk_t%0d_m1_gnt", i), 32'(bus.m1_gnt), 32'h0);
      check_eq($sformatf("lk_t%0d_addr", i),   32'(bus.mem_address), 32'h41);
    end
    next_cycle();
    bus.m0_req  = 1'b0;
    bus.m0_lock = 1'b0;
    settle();
    check_eq("lk_drop_m0_gnt", 32'(bus.m0_gnt), 32'h1);
    check_eq("lk_drop_noxfer", 32'(bus.mem_address), 32'h0);
    next_cycle(); settle();
    check_eq("lk_next_m1_gnt", 32'(bus.m1_gnt), 32'h1);
    check_eq("lk_next_m0_gnt", 32'(bus.m0_gnt), 32'h0);
    check_eq("lk_next_addr",   32'(bus.mem_address), 32'h82);
    idle_all();
    repeat (2) next_cycle();
    settle();
    check_eq("end_owner", 32'(owner_state), 32'(OWN_NONE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
